// File: rtl/sprite_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blit_engine
// Brief    : Avalon-MM master that copies one 16x16 sprite from SDRAM into
//            the frame buffer, skipping transparent pixels and clipping.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_blit_engine #(
  parameter logic [24:0] SPRITE_BASE = 25'h100000,
  parameter logic [24:0] FB_BASE     = 25'h000000,
  parameter int          FB_W        = 640,
  parameter int          FB_H        = 480
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  sprite_num,
  input  logic [19:0] xy_pos,
  input  logic [2:0]  sw_to_hw,
  output logic [1:0]  hw_to_sw,
  output logic [24:0] avm_address,
  output logic [3:0]  avm_byteenable_n,
  output logic        avm_chipselect,
  output logic [31:0] avm_writedata,
  output logic        avm_read_n,
  output logic        avm_write_n,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  localparam logic [10:0] FB_W_11 = 11'(FB_W);
  localparam logic [10:0] FB_H_11 = 11'(FB_H);
  localparam logic [24:0] FB_W_25 = 25'(FB_W);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic        armed_q, armed_d;
  logic [1:0]  sprite_q, sprite_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [24:0] line_base_q, line_base_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [24:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_n_q, read_n_d;
  logic        write_n_q, write_n_d;
  logic        cs_q, cs_d;

  logic        w_start_edge;
  logic        w_abort;
  logic        w_clip;
  logic        w_last;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [24:0] w_line_start;
  logic [24:0] w_rd_addr;
  logic [24:0] w_wr_addr;
  logic        unused_reserved;

  // armed_q blocks a start that was already high when reset was released
  assign w_start_edge    = sw_to_hw[0] & ~start_q & armed_q;
  assign w_abort         = sw_to_hw[1];
  assign unused_reserved = sw_to_hw[2];
  assign w_px            = {1'b0, x_q} + {7'b0, col_q};
  assign w_py            = {1'b0, y_q} + {7'b0, row_q};
  assign w_clip          = (w_px >= FB_W_11) || (w_py >= FB_H_11);
  assign w_last          = (row_q == 4'd15) && (col_q == 4'd15);
  assign w_line_start    = FB_BASE + 25'(xy_pos[19:10]) * FB_W_25;
  assign w_rd_addr       = SPRITE_BASE + {15'b0, sprite_q, row_q, col_q};
  assign w_wr_addr       = line_base_q + {15'b0, x_q} + {21'b0, col_q};

  always_comb begin
    state_d     = state_q;
    start_d     = sw_to_hw[0];
    armed_d     = armed_q | ~sw_to_hw[0];
    sprite_d    = sprite_q;
    x_d         = x_q;
    y_d         = y_q;
    row_d       = row_q;
    col_d       = col_q;
    line_base_d = line_base_q;
    busy_d      = busy_q;
    done_d      = done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    cs_d        = cs_q;
    case (state_q)
      S_IDLE: begin
        if (w_start_edge) begin
          sprite_d    = sprite_num;
          x_d         = xy_pos[9:0];
          y_d         = xy_pos[19:10];
          row_d       = 4'd0;
          col_d       = 4'd0;
          line_base_d = w_line_start;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_abort) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (w_clip) begin
          state_d = S_NEXT;
        end else begin
          read_n_d = 1'b0;
          cs_d     = 1'b1;
          addr_d   = w_rd_addr;
          state_d  = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          read_n_d = 1'b1;
          cs_d     = 1'b0;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata[24]) begin
            write_n_d = 1'b0;
            cs_d      = 1'b1;
            addr_d    = w_wr_addr;
            wdata_d   = avm_readdata;
            state_d   = S_WR_REQ;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) begin
          write_n_d = 1'b1;
          cs_d      = 1'b0;
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_abort || w_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          col_d = col_q + 4'd1;
          if (col_q == 4'd15) begin
            row_d       = row_q + 4'd1;
            line_base_d = line_base_q + FB_W_25;
          end
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      sprite_q    <= 2'd0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      row_q       <= 4'd0;
      col_q       <= 4'd0;
      line_base_q <= 25'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= 25'd0;
      wdata_q     <= 32'd0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      cs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      armed_q     <= armed_d;
      sprite_q    <= sprite_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_q       <= row_d;
      col_q       <= col_d;
      line_base_q <= line_base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      cs_q        <= cs_d;
    end
  end

  assign hw_to_sw         = {done_q, busy_q};
  assign avm_address      = addr_q;
  assign avm_byteenable_n = 4'b0000;
  assign avm_chipselect   = cs_q;
  assign avm_writedata    = wdata_q;
  assign avm_read_n       = read_n_q;
  assign avm_write_n      = write_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_blit_engine
// Brief    : Directed bench for sprite_blit_engine with an SDRAM slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blit_engine;

  localparam logic [24:0] SPRITE_BASE = 25'h100000;
  localparam logic [24:0] FB_BASE     = 25'h000000;
  localparam int PAT_SOLID = 0;
  localparam int PAT_CHECK = 1;
  localparam int PAT_GRAD  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sprite_num = 2'd0;
  logic [19:0] xy_pos = 20'd0;
  logic [2:0]  sw_to_hw = 3'd0;
  logic [1:0]  hw_to_sw;
  logic [24:0] avm_address;
  logic [3:0]  avm_byteenable_n;
  logic        avm_chipselect;
  logic [31:0] avm_writedata;
  logic        avm_read_n;
  logic        avm_write_n;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;

  sprite_blit_engine dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .sprite_num        (sprite_num),
    .xy_pos            (xy_pos),
    .sw_to_hw          (sw_to_hw),
    .hw_to_sw          (hw_to_sw),
    .avm_address       (avm_address),
    .avm_byteenable_n  (avm_byteenable_n),
    .avm_chipselect    (avm_chipselect),
    .avm_writedata     (avm_writedata),
    .avm_read_n        (avm_read_n),
    .avm_write_n       (avm_write_n),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] fb_got [int];
  logic [31:0] exp_img [int];
  int n_wr, n_rd, n_dup;
  int cur_s, cur_x, cur_y;
  bit rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fill(input int s, input int pat);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h01DEAD00 | 32'(i);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int idx;
        idx = s * 256 + r * 16 + c;
        case (pat)
          PAT_SOLID: mem[idx] = 32'h01FF0000;
          PAT_CHECK: mem[idx] = 32'h5AA00000 | 32'(r << 12) | 32'(c << 4) |
                                (((r ^ c) % 2 == 0) ? 32'h01000000 : 32'h0);
          default:   mem[idx] = 32'h5B000000 | 32'(s << 16) | 32'(r << 8) | 32'(c);
        endcase
      end
  endtask

  // independent reference image: opaque, on-screen pixels only
  task automatic build_expected(input int s, input int x, input int y);
    exp_img.delete();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        logic [31:0] w;
        w = mem[s * 256 + r * 16 + c];
        if (w[24] && (x + c < 640) && (y + r < 480))
          exp_img[int'(FB_BASE) + (y + r) * 640 + x + c] = w;
      end
  endtask

  task automatic cmp_image(input string tag);
    int bad;
    bad = 0;
    foreach (exp_img[a]) if (!fb_got.exists(a) || fb_got[a] !== exp_img[a]) bad++;
    foreach (fb_got[a]) if (!exp_img.exists(a)) bad++;
    check({tag, "_image"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [31:0] mem_read(input logic [24:0] a);
    int off;
    off = int'(a) - int'(SPRITE_BASE);
    if (off >= 0 && off < 1024) return mem[off];
    return 32'hBAD0BAD0;
  endfunction

  // Avalon slave model and protocol monitor
  initial begin : slave
    bit          p_rd, p_wr, p_wait, pend;
    logic [24:0] p_addr, r_addr;
    logic [31:0] p_data;
    int          dly;
    p_rd = 0; p_wr = 0; p_wait = 0; pend = 0; p_addr = 0; r_addr = 0; p_data = 0; dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        p_rd = 0; p_wr = 0; p_wait = 0; pend = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        continue;
      end
      if (p_rd && !p_wait) begin
        int  off;
        bit  ok;
        off = int'(p_addr) - int'(SPRITE_BASE);
        ok  = (off >= 0) && (off < 1024) && (off / 256 == cur_s) &&
              (cur_x + off % 16 < 640) && (cur_y + (off / 16) % 16 < 480);
        check("rd_addr", 64'(ok), 64'd1);
        n_rd++;
        pend   = 1'b1;
        dly    = rand_mode ? int'($urandom_range(1, 7)) : 1;
        r_addr = p_addr;
      end
      if (p_wr && !p_wait) begin
        int off;
        off = int'(p_addr) - int'(FB_BASE);
        check("wr_in_screen", 64'(off >= 0 && off / 640 < 480), 64'd1);
        n_wr++;
        if (fb_got.exists(int'(p_addr))) n_dup++;
        fb_got[int'(p_addr)] = p_data;
      end
      avm_readdatavalid = 1'b0;
      if (pend) begin
        dly--;
        if (dly == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem_read(r_addr);
          pend              = 1'b0;
        end
      end
      if (p_wait && (p_rd || p_wr))
        check("stall_hold", {5'd0, avm_read_n, avm_write_n, avm_address, avm_writedata},
              {5'd0, !p_rd, !p_wr, p_addr, p_data});
      check("chipselect", 64'(avm_chipselect), 64'(!avm_read_n || !avm_write_n));
      avm_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      p_rd   = !avm_read_n;
      p_wr   = !avm_write_n;
      p_addr = avm_address;
      p_data = avm_writedata;
      p_wait = avm_waitrequest;
    end
  end

  task automatic setup(input int s, input int x, input int y, input bit rm);
    cur_s = s; cur_x = x; cur_y = y; rand_mode = rm;
    fb_got.delete();
    n_wr = 0; n_rd = 0; n_dup = 0;
    sprite_num = 2'(s);
    xy_pos     = {10'(y), 10'(x)};
  endtask

  task automatic run_blit(input int s, input int x, input int y, input bit rm,
                          input bit first_rd, output int cyc, output bit to);
    setup(s, x, y, rm);
    @(posedge clk); #2;
    sw_to_hw[0] = 1'b1;
    @(posedge clk); #2;
    check("busy_rise", 64'(hw_to_sw), 64'd1);
    @(posedge clk); #2;
    check("first_rd", 64'(!avm_read_n), 64'(first_rd));
    sw_to_hw[0] = 1'b0;
    cyc = 2;
    to  = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #2;
      if (!hw_to_sw[0]) begin
        to = 1'b0;
        break;
      end
      cyc++;
    end
    check("blit_timeout", 64'(to), 64'd0);
    check("done_state", 64'(hw_to_sw), 64'd2);
    repeat (3) @(posedge clk);
    #2;
  endtask

  typedef struct {
    int s, x, y, pat;
    bit rm, first_rd;
    int exp_wr, exp_rd, exp_cyc;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int cyc, cnt;
    bit to;
    vecs[0] = '{1, 100, 50,  PAT_SOLID, 1'b0, 1'b1, 256, 256, 1280};
    vecs[1] = '{0, 0,   0,   PAT_CHECK, 1'b0, 1'b1, 128, 256, 1152};
    vecs[2] = '{2, 632, 472, PAT_GRAD,  1'b0, 1'b1, 64,  64,  704};
    vecs[3] = '{1, 100, 50,  PAT_GRAD,  1'b1, 1'b1, 256, 256, -1};
    vecs[4] = '{3, 639, 479, PAT_GRAD,  1'b0, 1'b1, 1,   1,   515};
    vecs[5] = '{3, 1023, 1023, PAT_GRAD, 1'b0, 1'b0, 0,  0,   512};
    vecs[6] = '{0, 0,   0,   PAT_CHECK, 1'b1, 1'b1, 128, 256, -1};

    // reset with start held high must not launch a blit
    sw_to_hw = 3'b001;
    repeat (3) @(posedge clk);
    #2;
    check("rst_read_n",  64'(avm_read_n), 64'd1);
    check("rst_write_n", 64'(avm_write_n), 64'd1);
    check("rst_cs",      64'(avm_chipselect), 64'd0);
    check("rst_addr",    64'(avm_address), 64'd0);
    check("rst_wdata",   64'(avm_writedata), 64'd0);
    check("rst_status",  64'(hw_to_sw), 64'd0);
    check("byteenable",  64'(avm_byteenable_n), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("held_start_busy", 64'(hw_to_sw), 64'd0);
    check("held_start_rd",   64'(avm_read_n), 64'd1);
    sw_to_hw = 3'b000;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      fill(vecs[k].s, vecs[k].pat);
      build_expected(vecs[k].s, vecs[k].x, vecs[k].y);
      run_blit(vecs[k].s, vecs[k].x, vecs[k].y, vecs[k].rm, vecs[k].first_rd, cyc, to);
      check($sformatf("v%0d_writes", k), 64'(n_wr), 64'(vecs[k].exp_wr));
      check($sformatf("v%0d_reads", k), 64'(n_rd), 64'(vecs[k].exp_rd));
      check($sformatf("v%0d_dups", k), 64'(n_dup), 64'd0);
      if (vecs[k].exp_cyc >= 0)
        check($sformatf("v%0d_cycles", k), 64'(cyc), 64'(vecs[k].exp_cyc));
      cmp_image($sformatf("v%0d", k));
    end

    // second start while busy is ignored; abort after pixel 20
    fill(1, PAT_GRAD);
    build_expected(1, 100, 50);
    setup(1, 100, 50, 1'b0);
    @(posedge clk); #2;
    sw_to_hw[0] = 1'b1;
    @(posedge clk); #2;
    sw_to_hw[0] = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (n_wr >= 5) begin to = 1'b0; break; end
    end
    check("abort_wait5", 64'(to), 64'd0);
    sprite_num  = 2'd2;
    xy_pos      = {10'd7, 10'd9};
    sw_to_hw[0] = 1'b1;
    @(posedge clk); #2;
    sw_to_hw[0] = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (n_wr >= 20) begin to = 1'b0; break; end
    end
    check("abort_wait20", 64'(to), 64'd0);
    sw_to_hw[1] = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (!hw_to_sw[0]) begin to = 1'b0; break; end
    end
    check("abort_timeout", 64'(to), 64'd0);
    check("abort_status", 64'(hw_to_sw), 64'd2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (!avm_read_n || !avm_write_n) cnt++;
    end
    check("abort_quiet", 64'(cnt), 64'd0);
    check("abort_writes", 64'(n_wr), 64'd20);
    cnt = 0;
    foreach (fb_got[a]) if (!exp_img.exists(a) || exp_img[a] !== fb_got[a]) cnt++;
    check("abort_data", 64'(cnt), 64'd0);
    sw_to_hw[1] = 1'b0;
    repeat (2) @(posedge clk);

    // asynchronous reset in the middle of a write request
    fill(1, PAT_SOLID);
    build_expected(1, 100, 50);
    setup(1, 100, 50, 1'b0);
    @(posedge clk); #2;
    sw_to_hw[0] = 1'b1;
    @(posedge clk); #2;
    sw_to_hw[0] = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (!avm_write_n) begin to = 1'b0; break; end
    end
    check("wr_req_seen", 64'(to), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write_n", 64'(avm_write_n), 64'd1);
    check("mid_rst_cs",      64'(avm_chipselect), 64'd0);
    check("mid_rst_status",  64'(hw_to_sw), 64'd0);
    @(posedge clk); #2;
    check("mid_rst_edge", {61'd0, avm_write_n, avm_chipselect, 1'b0} | 64'(hw_to_sw), 64'h4);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_blit(1, 100, 50, 1'b0, 1'b1, cyc, to);
    check("post_rst_writes", 64'(n_wr), 64'd256);
    check("post_rst_cycles", 64'(cyc), 64'd1280);
    cmp_image("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
